fetch_ctrl: RTL and testbench

Sequencing controller for the instruction-fetch path. It owns the fetch PC and drives a request/grant/response instruction-memory port, so instruction memory may have variable latency. It discards responses made stale by a branch redirect and presents fetched instructions to the IF/ID boundary through a one-entry valid/ready buffer. It replaces the free-running PC register and next-PC mux: redirect and stall inputs from EX and the hazard unit now arrive as handshakes.

---
 rtl/fetch_ctrl_pkg.sv | 15 +
 rtl/fetch_buffer.sv | 53 +++++
 rtl/fetch_ctrl.sv | 100 ++++++++++
 tb/tb_fetch_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared widths, reset PC and fetch FSM state type
package fetch_ctrl_pkg;

  localparam int DATA_WIDTH          = 32;
  localparam int INST_MEM_ADDR_WIDTH = 10;

  localparam logic [DATA_WIDTH-1:0] RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    FS_REQ,
    FS_WAIT,
    FS_KILL
  } fetch_state_e;

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - one-entry valid/ready holding register for the IF/ID boundary
module fetch_buffer
  import fetch_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  fill_i,
  input  logic [DATA_WIDTH-1:0] fill_instr_i,
  input  logic [DATA_WIDTH-1:0] fill_pc_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] pc_o
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;

  // Flush wins over a same-cycle fill or consume so stale work never reaches decode.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (fill_i) begin
      valid_d = 1'b1;
      instr_d = fill_instr_i;
      pc_d    = fill_pc_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch PC sequencer with req/gnt/rvalid imem port and redirect kill
module fetch_ctrl
  import fetch_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_target_i,
  output logic                  imem_req_o,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  output logic                  if_valid_o,
  output logic [DATA_WIDTH-1:0] if_instr_o,
  output logic [DATA_WIDTH-1:0] if_pc_o,
  output logic [DATA_WIDTH-1:0] if_pc_plus4_o,
  input  logic                  id_ready_i,
  output logic                  misalign_err_o
);

  fetch_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] req_pc_q, req_pc_d;
  logic                  run_q;
  logic                  misalign_err_q, misalign_err_d;
  logic                  buf_fill;
  logic                  buf_valid;

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    req_pc_d       = req_pc_q;
    misalign_err_d = misalign_err_q;
    buf_fill       = 1'b0;
    imem_req_o     = 1'b0;
    unique case (state_q)
      FS_REQ: begin
        // Only ask when the buffer is free by the time the response lands.
        imem_req_o = run_q && (!buf_valid || id_ready_i);
        if (imem_req_o && imem_gnt_i) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + 32'd4;
          state_d  = redirect_i ? FS_KILL : FS_WAIT;
        end
      end
      FS_WAIT: begin
        if (imem_rvalid_i) begin
          buf_fill = !redirect_i;
          state_d  = FS_REQ;
        end else if (redirect_i) begin
          state_d = FS_KILL;
        end
      end
      FS_KILL: begin
        if (imem_rvalid_i) state_d = FS_REQ;
      end
      default: state_d = FS_REQ;
    endcase
    if (redirect_i) begin
      pc_d = {redirect_target_i[DATA_WIDTH-1:2], 2'b00};
      if (redirect_target_i[1:0] != 2'b00) misalign_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= FS_REQ;
      pc_q           <= RESET_PC;
      req_pc_q       <= '0;
      run_q          <= 1'b0;
      misalign_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      req_pc_q       <= req_pc_d;
      run_q          <= 1'b1;
      misalign_err_q <= misalign_err_d;
    end
  end

  fetch_buffer u_fetch_buffer (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (redirect_i),
    .fill_i       (buf_fill),
    .fill_instr_i (imem_rdata_i),
    .fill_pc_i    (req_pc_q),
    .ready_i      (id_ready_i),
    .valid_o      (buf_valid),
    .instr_o      (if_instr_o),
    .pc_o         (if_pc_o)
  );

  assign imem_addr_o    = pc_q;
  assign if_valid_o     = buf_valid;
  assign if_pc_plus4_o  = if_pc_o + 32'd4;
  assign misalign_err_o = misalign_err_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - scoreboard bench for fetch_ctrl with a variable-latency memory model
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_i;
  logic [31:0] redirect_target_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        if_valid_o;
  logic [31:0] if_instr_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_pc_plus4_o;
  logic        id_ready_i;
  logic        misalign_err_o;

  logic        gnt_en;
  int          lat;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  assign imem_gnt_i = imem_req_o & gnt_en;

  fetch_ctrl dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .redirect_i        (redirect_i),
    .redirect_target_i (redirect_target_i),
    .imem_req_o        (imem_req_o),
    .imem_addr_o       (imem_addr_o),
    .imem_gnt_i        (imem_gnt_i),
    .imem_rvalid_i     (imem_rvalid_i),
    .imem_rdata_i      (imem_rdata_i),
    .if_valid_o        (if_valid_o),
    .if_instr_o        (if_instr_o),
    .if_pc_o           (if_pc_o),
    .if_pc_plus4_o     (if_pc_plus4_o),
    .id_ready_i        (id_ready_i),
    .misalign_err_o    (misalign_err_o)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ~a ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int max);
    for (int i = 0; i < max; i++) begin
      @(posedge clk);
      if (exp_q.size() == 0) return;
    end
    checks++;
    errors++;
    $display("FAIL drain_timeout: %0d deliveries still pending, expected 0", exp_q.size());
    exp_q.delete();
  endtask

  // Memory: grant follows gnt_en; the response comes lat cycles after the grant cycle.
  initial begin
    logic        fire, pend;
    logic [31:0] faddr, paddr;
    int          cnt;
    pend = 1'b0;
    paddr = '0;
    cnt = 0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i = '0;
    forever begin
      @(negedge clk);
      fire  = imem_req_o && imem_gnt_i && rst_n;
      faddr = imem_addr_o;
      @(posedge clk);
      #1;
      imem_rvalid_i = 1'b0;
      if (!rst_n) begin
        pend = 1'b0;
      end else begin
        if (fire) begin
          pend  = 1'b1;
          cnt   = lat;
          paddr = faddr;
        end
        if (pend) begin
          cnt--;
          if (cnt == 0) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_word(paddr);
            pend          = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: every instruction decode accepts must be the next one the stimulus queued.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && if_valid_o && id_ready_i && !redirect_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_delivery: got pc 0x%08h expected none", if_pc_o);
        end else begin
          e = exp_q.pop_front();
          chk("deliv_pc", if_pc_o, e);
          chk("deliv_instr", if_instr_o, mem_word(e));
          chk("deliv_pc_plus4", if_pc_plus4_o, e + 32'd4);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    redirect_i = 1'b0;
    redirect_target_i = '0;
    id_ready_i = 1'b1;
    gnt_en = 1'b1;
    lat = 1;
    repeat (3) cyc();
    @(negedge clk);
    chk("rst_req", {31'd0, imem_req_o}, 32'd0);
    chk("rst_addr", imem_addr_o, 32'h0);
    chk("rst_valid", {31'd0, if_valid_o}, 32'd0);
    chk("rst_instr", if_instr_o, 32'h0);
    chk("rst_pc", if_pc_o, 32'h0);
    chk("rst_pc_plus4", if_pc_plus4_o, 32'h4);
    chk("rst_misalign", {31'd0, misalign_err_o}, 32'd0);

    // Streaming with one-cycle memory
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    exp_q.push_back(32'hC);
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("boot_req_c0", {31'd0, imem_req_o}, 32'd0);
    cyc();
    @(negedge clk);
    chk("boot_req_c1", {31'd0, imem_req_o}, 32'd1);
    chk("boot_addr_c1", imem_addr_o, 32'h0);
    chk("boot_valid_c1", {31'd0, if_valid_o}, 32'd0);
    wait_drain(40);

    // Backpressure with the buffer holding PC 16
    #1 id_ready_i = 1'b0;
    cyc();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_req", {31'd0, imem_req_o}, 32'd0);
      chk("bp_pc", if_pc_o, 32'h10);
      chk("bp_instr", if_instr_o, mem_word(32'h10));
      cyc();
    end
    exp_q.push_back(32'h10);
    exp_q.push_back(32'h14);
    exp_q.push_back(32'h18);
    id_ready_i = 1'b1;
    @(negedge clk);
    chk("bp_release_req", {31'd0, imem_req_o}, 32'd1);
    chk("bp_release_addr", imem_addr_o, 32'h14);
    wait_drain(40);

    // Redirect in FS_WAIT with two-cycle memory
    #1 id_ready_i = 1'b0;
    repeat (3) cyc();
    lat = 2;
    exp_q.push_back(32'h1C);
    cyc();
    id_ready_i = 1'b1;
    cyc();
    redirect_i = 1'b1;
    redirect_target_i = 32'h100;
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    cyc();
    redirect_i = 1'b0;
    @(negedge clk);
    chk("kill_valid", {31'd0, if_valid_o}, 32'd0);
    cyc();
    @(negedge clk);
    chk("kill_req", {31'd0, imem_req_o}, 32'd1);
    chk("kill_addr", imem_addr_o, 32'h100);
    wait_drain(60);

    // Redirect coincident with rvalid
    #1 id_ready_i = 1'b0;
    repeat (4) cyc();
    lat = 1;
    exp_q.push_back(32'h108);
    cyc();
    id_ready_i = 1'b1;
    cyc();
    redirect_i = 1'b1;
    redirect_target_i = 32'h200;
    exp_q.push_back(32'h200);
    cyc();
    redirect_i = 1'b0;
    @(negedge clk);
    chk("coinc_valid", {31'd0, if_valid_o}, 32'd0);
    chk("coinc_req", {31'd0, imem_req_o}, 32'd1);
    chk("coinc_addr", imem_addr_o, 32'h200);
    wait_drain(40);

    // Redirect in FS_REQ with the request not granted
    #1 id_ready_i = 1'b0;
    repeat (3) cyc();
    gnt_en = 1'b0;
    exp_q.push_back(32'h204);
    cyc();
    id_ready_i = 1'b1;
    cyc();
    redirect_i = 1'b1;
    redirect_target_i = 32'h300;
    @(negedge clk);
    chk("nogrant_req", {31'd0, imem_req_o}, 32'd1);
    cyc();
    redirect_i = 1'b0;
    gnt_en = 1'b1;
    exp_q.push_back(32'h300);
    @(negedge clk);
    chk("nogrant_reissue_req", {31'd0, imem_req_o}, 32'd1);
    chk("nogrant_reissue_addr", imem_addr_o, 32'h300);
    wait_drain(40);

    // Misaligned redirect target
    #1 redirect_i = 1'b1;
    redirect_target_i = 32'h102;
    exp_q.push_back(32'h100);
    cyc();
    redirect_i = 1'b0;
    @(negedge clk);
    chk("misalign_flag", {31'd0, misalign_err_o}, 32'd1);
    chk("misalign_req", {31'd0, imem_req_o}, 32'd1);
    chk("misalign_addr", imem_addr_o, 32'h100);
    wait_drain(40);

    // Redirect to the top of the address space: PC+4 wraps
    #1 redirect_i = 1'b1;
    redirect_target_i = 32'hFFFF_FFFC;
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    cyc();
    redirect_i = 1'b0;
    wait_drain(40);
    #1 id_ready_i = 1'b0;
    @(negedge clk);
    chk("misalign_sticky", {31'd0, misalign_err_o}, 32'd1);
    repeat (3) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
